// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives active-low column strobes, synchronizes the
// active-low row returns, debounces press/release and reports one code per press.
module keypad_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int DEB_TICKS = 10
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [3:0] read_code,
    output logic [3:0] scan_code,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEB_W  = $clog2(DEB_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        rows_m, rows_s;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        col, col_nx;
    logic [1:0]        row_l, row_nx;
    logic [DEB_W-1:0]  deb_cnt, deb_nx;
    logic [DEB_W-1:0]  rel_cnt, rel_nx;
    logic [3:0]        code_nx;
    logic              valid_nx;
    logic              down_nx;

    function automatic logic single_low(input logic [3:0] rows);
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        case (rows)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        case ({c, r})
            4'b00_00: key_map = 4'h1;
            4'b00_01: key_map = 4'h4;
            4'b00_10: key_map = 4'h7;
            4'b00_11: key_map = 4'hE;
            4'b01_00: key_map = 4'h2;
            4'b01_01: key_map = 4'h5;
            4'b01_10: key_map = 4'h8;
            4'b01_11: key_map = 4'h0;
            4'b10_00: key_map = 4'h3;
            4'b10_01: key_map = 4'h6;
            4'b10_10: key_map = 4'h9;
            4'b10_11: key_map = 4'hF;
            4'b11_00: key_map = 4'hA;
            4'b11_01: key_map = 4'hB;
            4'b11_10: key_map = 4'hC;
            default:  key_map = 4'hD;
        endcase
    endfunction

    // Row returns are asynchronous to sys_clk; idle (released) level is all ones.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rows_m <= 4'b1111;
            rows_s <= 4'b1111;
        end else begin
            rows_m <= read_code;
            rows_s <= rows_m;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_nx = state;
        col_nx   = col;
        row_nx   = row_l;
        deb_nx   = deb_cnt;
        rel_nx   = rel_cnt;
        code_nx  = key_code;
        valid_nx = 1'b0;
        down_nx  = key_down;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single_low(rows_s)) begin
                        row_nx   = low_index(rows_s);
                        deb_nx   = DEB_W'(1);
                        state_nx = DEB_PRESS;
                    end else begin
                        col_nx = col + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (rows_s == ~(4'b0001 << row_l)) begin
                        if (deb_cnt == DEB_W'(DEB_TICKS - 1)) begin
                            code_nx  = key_map(col, row_l);
                            valid_nx = 1'b1;
                            down_nx  = 1'b1;
                            deb_nx   = '0;
                            rel_nx   = '0;
                            state_nx = HELD;
                        end else begin
                            deb_nx = deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        // Bounce or pattern change: abandon and keep scanning.
                        deb_nx   = '0;
                        col_nx   = col + 2'd1;
                        state_nx = SCAN;
                    end
                end
                HELD: begin
                    // Only the latched row matters; other keys on this column are ignored.
                    if (rows_s[row_l]) begin
                        if (rel_cnt == DEB_W'(DEB_TICKS - 1)) begin
                            down_nx  = 1'b0;
                            rel_nx   = '0;
                            col_nx   = col + 2'd1;
                            state_nx = SCAN;
                        end else begin
                            rel_nx = rel_cnt + DEB_W'(1);
                        end
                    end else begin
                        rel_nx = '0;
                    end
                end
                default: begin
                    state_nx = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col       <= 2'd0;
            row_l     <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            scan_code <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            row_l     <= row_nx;
            deb_cnt   <= deb_nx;
            rel_cnt   <= rel_nx;
            scan_code <= ~(4'b0001 << col_nx);
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_down  <= down_nx;
        end
    end

endmodule
